div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. The execute stage drives operands and a start request, holds the pipeline stalled while `ready_o` is low, then captures the 64-bit result {remainder, quotient} into HI/LO. The implementation is a radix-2 restoring divider: one quotient bit per cycle, sign handling at entry and exit.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported. Counter width is 6 bits.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `signed_div_i` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` input 32: dividend (rs).
- `opdata2_i` input 32: divisor (rt).
- `start_i` input 1: division request; held high by execute until `ready_o` is seen.
- `annul_i` input 1: abort the current division (pipeline flush).
- `result_o` output 64: {remainder[63:32], quotient[31:0]}; valid only while `ready_o` = 1.
- `ready_o` output 1: result valid.

## Operation
- State machine has four states: FREE, BYZERO, ON, END. Reset state is FREE. All outputs are 0 in reset.
- FREE:
  - `start_i`=1, `annul_i`=0, divisor=0 → BYZERO.
  - `start_i`=1, `annul_i`=0, divisor≠0 → ON. On this transition, latch the operands: |dividend| and |divisor| when `signed_div_i`=1 and the sign bit is set, raw values otherwise. Also latch the sign flags. Clear the counter and the partial remainder.
  - Otherwise stay in FREE, `ready_o`=0, `result_o`=0.
- BYZERO: load result 0 → END.
- ON, one iteration per cycle:
  - Form the trial value {rem[31:0], dividend msb} − divisor, 33-bit.
  - If non-negative: remainder = difference, quotient bit = 1. Else: remainder = shifted value, quotient bit = 0.
  - Shift the dividend left, increment the counter.
  - After the iteration with counter = 31 → END.
  - While in ON, `annul_i`=1 → FREE next cycle, result discarded.
- END:
  - `ready_o`=1.
  - `result_o` = {remainder, quotient} after sign fix-up. Quotient is negated when the signs differ and `signed_div_i`. Remainder takes the sign of the dividend.
  - Stay in END while `start_i`=1. `start_i`=0 → FREE, with `ready_o` and `result_o` returning to 0 on that edge.
- `annul_i` in END or BYZERO → FREE.
- −2^31 / −1 (signed): quotient 0x8000_0000 (wraps), remainder 0. No exception is raised.
- Operands are sampled only on the FREE→ON transition. Input changes during ON are ignored.
- Reset asserted mid-operation: immediate return to FREE, all outputs 0.

## Timing
- Normal latency: start is sampled at edge 0, ON occupies edges 1–32, END is entered at edge 33. `ready_o` is high from the cycle after edge 33. The execute stage therefore stalls for 34 cycles.
- Divide-by-zero: FREE→BYZERO (edge 0) → END (edge 1). `ready_o` is high after 2 edges.
- `ready_o` is registered, not combinational from inputs.
- Back-to-back divisions: after END→FREE, a new start is accepted on the following edge. There is a minimum 1 idle cycle between results.
- `annul_i` takes priority over `start_i` in every state.

## Configuration
- `DIV_EARLY_OUT_EN`, when defined:
  - In FREE, if |dividend| < |divisor| with a non-zero divisor, go to BYZERO-like fast path instead of ON.
  - Result = {dividend, 0}, with the remainder keeping the dividend's original value/sign.
  - END is reached after 2 edges.
- When undefined: every non-zero-divisor division takes the full 34-cycle path. Results are identical in both builds; only latency differs.

## Test plan
- DIVU 100 / 7, start held → `ready_o` at cycle 34. `result_o` = {0x0000_0002, 0x0000_000E}. Drop start → `ready_o`=0 next cycle.
- DIV −7 / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. DIV 7 / −2 → quotient 0xFFFF_FFFD, remainder 0x0000_0001.
- DIV 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0, no hang.
- Divisor 0, dividend 0x1234 → `ready_o` after 2 edges, `result_o`=0.
- Start 50 / 3, assert `annul_i` at cycle 10 → FREE, `ready_o` never rises. A new 9 / 3 immediately after yields {0, 3} at cycle 34.
- 3 / 5 unsigned: with `DIV_EARLY_OUT_EN` → `ready_o` after 2 edges. Without it → after 34. Both give {0x3, 0x0}.
- Reset pulse at cycle 15 of a division → outputs 0 at once, state FREE.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle on unsigned magnitudes, with the sign fix-up
// applied on the way into END. The execute stage holds start_i until
// ready_o is seen and drops it to release the unit.
// Optional build macro: DIV_EARLY_OUT_EN. When defined, |dividend| < |divisor|
// skips the iteration and completes in 2 edges. Results match the default build.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BYZERO = 2'b01;
    localparam logic [1:0] ON     = 2'b10;
    localparam logic [1:0] END    = 2'b11;

    // The counter runs 0..WIDTH; the extra count is the fix-up cycle.
    localparam logic [5:0] LAST_CNT = 6'(WIDTH);

    logic [1:0]       state;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] dividend;   // shifts left, msb feeds each trial
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;        // partial remainder
    logic [WIDTH-1:0] quot;       // quotient bits shift in at the lsb
    logic             neg_quot;
    logic             neg_rem;

    logic [WIDTH-1:0] abs_op1;
    logic [WIDTH-1:0] abs_op2;
    logic [WIDTH:0]   trial;
    logic             early_out;

    // Operand magnitudes and the 33-bit trial subtraction for this cycle.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        abs_op1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs_op2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        trial   = {rem, dividend[WIDTH-1]} - {1'b0, divisor};
    end

`ifdef DIV_EARLY_OUT_EN
    // Quotient is zero whenever the dividend magnitude is smaller than the divisor.
    assign early_out = (abs_op1 < abs_op2);
`else
    assign early_out = 1'b0;
`endif

    // Divider state machine. The datapath and the registered outputs share one block.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quot     <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                            rem   <= '0;
                        end else if (early_out) begin
                            // Remainder is the dividend itself, sign included.
                            state <= BYZERO;
                            rem   <= opdata1_i;
                        end else begin
                            state    <= ON;
                            dividend <= abs_op1;
                            divisor  <= abs_op2;
                            neg_quot <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
                            cnt      <= '0;
                            rem      <= '0;
                            quot     <= '0;
                        end
                    end
                end

                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {rem, {WIDTH{1'b0}}};
                    end
                end

                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else if (cnt != LAST_CNT) begin
                        if (!trial[WIDTH]) begin
                            rem  <= trial[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= {rem[WIDTH-2:0], dividend[WIDTH-1]};
                            quot <= {quot[WIDTH-2:0], 1'b0};
                        end
                        dividend <= {dividend[WIDTH-2:0], 1'b0};
                        cnt      <= cnt + 6'd1;
                    end else begin
                        // All bits done: apply signs and present the result.
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {(neg_rem  ? -rem  : rem),
                                     (neg_quot ? -quot : quot)};
                    end
                end

                END: begin
                    if (annul_i || !start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end

                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit with hand-computed results.
// Latency counts edges from the edge that samples start (edge 0 -> count 1)
// up to and including the edge after which ready_o is seen high.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = 34;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one division with start held, check latency, result, hold and release.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int n;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                // Operands are only sampled on entry; scramble them afterwards.
                opdata1_i = ~a;
                opdata2_i = b ^ 32'h0000_0005;
            end
        end while (!ready_o && n < 100);
        check({tag, "_latency"}, 65'(n), 65'(exp_lat));
        check({tag, "_result"}, {ready_o, result_o}, {1'b1, exp_res});
        tick();
        check({tag, "_hold"}, {ready_o, result_o}, {1'b1, exp_res});
        start_i = 1'b0;
        tick();
        check({tag, "_release"}, {ready_o, result_o}, 65'd0);
    endtask

    initial begin
        bit seen;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {ready_o, result_o}, 65'd0);
        rst = 1'b1;
        tick();
        check("idle_after_reset", {ready_o, result_o}, 65'd0);

        do_div("divu_100_7",  1'b0, 32'd100,       32'd7,         34, {32'h0000_0002, 32'h0000_000E});
        do_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 34, {32'h0000_0001, 32'hFFFF_FFFD});
        do_div("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'h0000_0000, 32'h8000_0000});
        do_div("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'h8000_0000, 32'h0000_0000});
        do_div("div_by_zero", 1'b0, 32'h0000_1234, 32'd0,          2, 64'd0);
        do_div("divu_3_5",    1'b0, 32'd3,         32'd5,  SMALL_LAT, {32'h0000_0003, 32'h0000_0000});
        do_div("div_m3_5",    1'b1, 32'hFFFF_FFFD, 32'd5,  SMALL_LAT, {32'hFFFF_FFFD, 32'h0000_0000});
        do_div("divu_big",    1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 34, {32'h0000_FFFF, 32'h0000_FFFF});

        // Annul at cycle 10 of 50 / 3: ready_o must never rise.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        check("annul_no_ready", 65'(seen), 65'd0);
        do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 34, {32'h0000_0000, 32'h0000_0003});

        // Reset pulse at cycle 15 of a division.
        opdata1_i = 32'd1000;
        opdata2_i = 32'd10;
        start_i   = 1'b1;
        repeat (15) tick();
        start_i = 1'b0;
        #2 rst = 1'b0;
        #1 check("reset_mid_div", {ready_o, result_o}, 65'd0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        check("reset_mid_div_free", 65'(seen), 65'd0);

        // Reset while a result is presented clears the outputs asynchronously.
        opdata1_i = 32'd20;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        repeat (2) tick();
        check("byzero_ready", {ready_o, result_o}, {1'b1, 64'd0});
        signed_div_i = 1'b0;
        opdata1_i    = 32'd20;
        opdata2_i    = 32'd6;
        start_i      = 1'b0;
        tick();
        start_i = 1'b1;
        repeat (34) tick();
        check("end_before_reset", {ready_o, result_o}, {1'b1, 32'h0000_0002, 32'h0000_0003});
        #2 rst = 1'b0;
        #1 check("reset_in_end", {ready_o, result_o}, 65'd0);
        start_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("idle_after_end_reset", {ready_o, result_o}, 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
